alu_seq_control: RTL and testbench
==================================

ALU_SEQ_CONTROL -- requirements
Module: alu_seq_control

Interface
Parameters (name, default, meaning):
REQ-001 ALUOP_WIDTH, 3, width of ALUOp from the main control unit.
REQ-002 OPER_WIDTH, 5, width of ALUOperation; SHALL be at least 5.
REQ-003 MULT_CYCLES, 4, busy cycles for MULT/MULTU; SHALL be at least 1.
REQ-004 DIV_CYCLES, 32, busy cycles for DIV/DIVU; SHALL be at least 1.
Ports (name, direction, width, meaning):
REQ-005 clk, in, 1: single clock; all state updates on the rising edge.
REQ-006 reset, in, 1: synchronous, active-high reset.
REQ-007 valid_i, in, 1: ALUOp/ALUFunction carry a new instruction.
REQ-008 ALUOp, in, ALUOP_WIDTH: operation class from the main control unit.
REQ-009 ALUFunction, in, 6: R-type funct field.
REQ-010 flush_i, in, 1: cancel any in-flight multi-cycle operation.
REQ-011 ready_o, out, 1: block accepts valid_i this cycle.
REQ-012 ALUOperation, out, OPER_WIDTH: registered ALU operation code.
REQ-013 op_valid, out, 1: ALUOperation is new this cycle (one-cycle pulse).
REQ-014 stall, out, 1: pipeline hold request, equal to NOT ready_o.
REQ-015 hilo_write, out, 1: one-cycle HI/LO write strobe at the end of a multiply or divide.
REQ-016 illegal_o, out, 1: one-cycle pulse for an undecodable selector.

Function
REQ-017 Transfer SHALL occur only in a cycle with valid_i=1 and ready_o=1; the selector is {ALUOp, ALUFunction}.
REQ-018 Decode: AND=0, OR/ORI=1, LUI=2, ADD/ADDU/ADDI/LW/SW=3, SLL=4, NOR=5, SRL=6, SUB/BEQ=7, JR=8, ILLEGAL=9, SLT=10, XOR=11, MULT=12, MULTU=13, DIV=14, DIVU=15, MFHI=16, MFLO=17.
REQ-019 The I-type ALUOp classes SHALL be: 110 ADDI, 101 ORI, 011 ANDI, 001 LUI, 010 LW, 100 SW, 000 BEQ; funct is ignored for these classes.
REQ-020 ALUOp 111 SHALL select R-type; funct 100100 AND, 100101 OR, 100111 NOR, 100000 ADD, 100001 ADDU, 100010 SUB, 000000 SLL, 000010 SRL, 001000 JR, 101010 SLT, 100110 XOR, 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO.
REQ-021 Any other selector SHALL produce code 9 and illegal_o=1 in the op_valid cycle.
REQ-022 Latency: for a transfer in cycle T, ALUOperation and op_valid=1 SHALL appear in cycle T+1; ALUOperation holds its value until the next transfer.
REQ-023 FSM states: IDLE, BUSY. IDLE sets ready_o=1. A transfer of codes 12–15 SHALL enter BUSY and load the counter with MULT_CYCLES or DIV_CYCLES; all other codes remain in IDLE.
REQ-024 BUSY sets ready_o=0 and stall=1, and decrements the counter every cycle. When the counter equals 1, hilo_write=1 and the next state is IDLE. Net effect: for N cycles, ready_o is low in T+1..T+N, hilo_write is high in T+N, and ready_o is high in T+N+1.
REQ-025 valid_i while in BUSY SHALL be ignored; the upstream stage holds the instruction.
REQ-026 flush_i in BUSY SHALL return the FSM to IDLE next cycle with no hilo_write. If the counter equals 1 in the same cycle, flush wins. flush_i in IDLE has no effect and does not block a same-cycle transfer.
REQ-027 The counter SHALL be $clog2(max(MULT_CYCLES,DIV_CYCLES)+1) bits wide and never wraps.
REQ-028 Back-to-back single-cycle transfers SHALL produce op_valid on consecutive cycles.

Reset
REQ-029 reset SHALL set: state IDLE, counter 0, ALUOperation 9, op_valid 0, hilo_write 0, illegal_o 0, ready_o 1, stall 0.
REQ-030 Reset SHALL take priority over every other input, including during BUSY; it aborts the operation with no hilo_write.

Structure
REQ-031 Package alu_control_pkg SHALL hold the operation-code constants, the ALUOp class encodings, and the funct constants.
REQ-032 Combinational decode SHALL live in sub-module alu_op_decoder (selector in; code, is_multicycle and illegal out). The FSM, counter and output registers stay in alu_seq_control.

Verification
REQ-033 ALUOp=111, funct=100000, valid_i for one cycle -> next cycle ALUOperation=3, op_valid=1, stall=0.
REQ-034 ALUOp=111, funct=011000, MULT_CYCLES=4, accepted at T -> ALUOperation=12 at T+1; stall high T+1..T+4; hilo_write only at T+4; ready_o high at T+5.
REQ-035 DIV (funct=011010, DIV_CYCLES=32) with flush_i at T+10 -> ready_o high at T+11; hilo_write never asserted.
REQ-036 ALUOp=111, funct=111111 -> ALUOperation=9 and illegal_o=1 for exactly one cycle; next transfer SLT (101010) -> ALUOperation=10.
REQ-037 reset asserted at T+2 of a MULT -> next cycle state IDLE, ALUOperation=9, ready_o=1, no hilo_write.
REQ-038 ALUOp=010 then 000 then 101 on consecutive cycles -> op_valid on three consecutive cycles with codes 3, 7, 1.

Source files
------------

// File: rtl/alu_control_pkg.sv
// Shared constants for the sequenced ALU control: operation codes, ALUOp classes
// and R-type funct values.
package alu_control_pkg;

    localparam int unsigned CodeW = 5;

    localparam logic [CodeW-1:0] OpAnd     = 5'd0;
    localparam logic [CodeW-1:0] OpOr      = 5'd1;
    localparam logic [CodeW-1:0] OpLui     = 5'd2;
    localparam logic [CodeW-1:0] OpAdd     = 5'd3;
    localparam logic [CodeW-1:0] OpSll     = 5'd4;
    localparam logic [CodeW-1:0] OpNor     = 5'd5;
    localparam logic [CodeW-1:0] OpSrl     = 5'd6;
    localparam logic [CodeW-1:0] OpSub     = 5'd7;
    localparam logic [CodeW-1:0] OpJr      = 5'd8;
    localparam logic [CodeW-1:0] OpIllegal = 5'd9;
    localparam logic [CodeW-1:0] OpSlt     = 5'd10;
    localparam logic [CodeW-1:0] OpXor     = 5'd11;
    localparam logic [CodeW-1:0] OpMult    = 5'd12;
    localparam logic [CodeW-1:0] OpMultu   = 5'd13;
    localparam logic [CodeW-1:0] OpDiv     = 5'd14;
    localparam logic [CodeW-1:0] OpDivu    = 5'd15;
    localparam logic [CodeW-1:0] OpMfhi    = 5'd16;
    localparam logic [CodeW-1:0] OpMflo    = 5'd17;

    localparam logic [2:0] ClsBeq   = 3'b000;
    localparam logic [2:0] ClsLui   = 3'b001;
    localparam logic [2:0] ClsLw    = 3'b010;
    localparam logic [2:0] ClsAndi  = 3'b011;
    localparam logic [2:0] ClsSw    = 3'b100;
    localparam logic [2:0] ClsOri   = 3'b101;
    localparam logic [2:0] ClsAddi  = 3'b110;
    localparam logic [2:0] ClsRtype = 3'b111;

    localparam logic [5:0] FunctAnd   = 6'b100100;
    localparam logic [5:0] FunctOr    = 6'b100101;
    localparam logic [5:0] FunctNor   = 6'b100111;
    localparam logic [5:0] FunctAdd   = 6'b100000;
    localparam logic [5:0] FunctAddu  = 6'b100001;
    localparam logic [5:0] FunctSub   = 6'b100010;
    localparam logic [5:0] FunctSll   = 6'b000000;
    localparam logic [5:0] FunctSrl   = 6'b000010;
    localparam logic [5:0] FunctJr    = 6'b001000;
    localparam logic [5:0] FunctSlt   = 6'b101010;
    localparam logic [5:0] FunctXor   = 6'b100110;
    localparam logic [5:0] FunctMult  = 6'b011000;
    localparam logic [5:0] FunctMultu = 6'b011001;
    localparam logic [5:0] FunctDiv   = 6'b011010;
    localparam logic [5:0] FunctDivu  = 6'b011011;
    localparam logic [5:0] FunctMfhi  = 6'b010000;
    localparam logic [5:0] FunctMflo  = 6'b010010;

    typedef enum logic [0:0] {StIdle, StBusy} seq_state_e;

    function automatic logic is_div_code(logic [CodeW-1:0] code);
        return (code == OpDiv) || (code == OpDivu);
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of {ALUOp, funct} into an ALU operation code, flagging
// multi-cycle (HI/LO) operations and undecodable selectors.
module alu_op_decoder
    import alu_control_pkg::*;
#(
    parameter int unsigned ALUOP_WIDTH = 3
) (
    input  logic [ALUOP_WIDTH+5:0] selector,
    output logic [CodeW-1:0]       code,
    output logic                   is_multicycle,
    output logic                   illegal
);

    // Class encodings widened to the ALUOp bus so any extra high bits must be zero.
    localparam logic [ALUOP_WIDTH-1:0] WBeq   = ALUOP_WIDTH'(ClsBeq);
    localparam logic [ALUOP_WIDTH-1:0] WLui   = ALUOP_WIDTH'(ClsLui);
    localparam logic [ALUOP_WIDTH-1:0] WLw    = ALUOP_WIDTH'(ClsLw);
    localparam logic [ALUOP_WIDTH-1:0] WAndi  = ALUOP_WIDTH'(ClsAndi);
    localparam logic [ALUOP_WIDTH-1:0] WSw    = ALUOP_WIDTH'(ClsSw);
    localparam logic [ALUOP_WIDTH-1:0] WOri   = ALUOP_WIDTH'(ClsOri);
    localparam logic [ALUOP_WIDTH-1:0] WAddi  = ALUOP_WIDTH'(ClsAddi);
    localparam logic [ALUOP_WIDTH-1:0] WRtype = ALUOP_WIDTH'(ClsRtype);

    logic [ALUOP_WIDTH-1:0] aluop;
    logic [5:0]             funct;

    assign aluop = selector[ALUOP_WIDTH+5:6];
    assign funct = selector[5:0];

    always_comb begin
        code = OpIllegal;
        case (aluop)
            WBeq:   code = OpSub;
            WLui:   code = OpLui;
            WLw:    code = OpAdd;
            WAndi:  code = OpAnd;
            WSw:    code = OpAdd;
            WOri:   code = OpOr;
            WAddi:  code = OpAdd;
            WRtype: begin
                case (funct)
                    FunctAnd:   code = OpAnd;
                    FunctOr:    code = OpOr;
                    FunctNor:   code = OpNor;
                    FunctAdd:   code = OpAdd;
                    FunctAddu:  code = OpAdd;
                    FunctSub:   code = OpSub;
                    FunctSll:   code = OpSll;
                    FunctSrl:   code = OpSrl;
                    FunctJr:    code = OpJr;
                    FunctSlt:   code = OpSlt;
                    FunctXor:   code = OpXor;
                    FunctMult:  code = OpMult;
                    FunctMultu: code = OpMultu;
                    FunctDiv:   code = OpDiv;
                    FunctDivu:  code = OpDivu;
                    FunctMfhi:  code = OpMfhi;
                    FunctMflo:  code = OpMflo;
                    default:    code = OpIllegal;
                endcase
            end
            default: code = OpIllegal;
        endcase
    end

    // No legal selector maps to the illegal code, so the flag follows directly from it.
    assign illegal       = (code == OpIllegal);
    assign is_multicycle = (code == OpMult) || (code == OpMultu) ||
                           (code == OpDiv)  || (code == OpDivu);

endmodule

// File: rtl/alu_seq_control.sv
// ALU control with registered operation code and an IDLE/BUSY sequencer that
// stalls the pipeline for multiply/divide and strobes the HI/LO write at the end.
module alu_seq_control
    import alu_control_pkg::*;
#(
    parameter int unsigned ALUOP_WIDTH = 3,
    parameter int unsigned OPER_WIDTH  = 5,
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_i,
    input  logic [ALUOP_WIDTH-1:0] ALUOp,
    input  logic [5:0]             ALUFunction,
    input  logic                   flush_i,
    output logic                   ready_o,
    output logic [OPER_WIDTH-1:0]  ALUOperation,
    output logic                   op_valid,
    output logic                   stall,
    output logic                   hilo_write,
    output logic                   illegal_o
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    seq_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [OPER_WIDTH-1:0] op_q, op_d;
    logic                  op_valid_q, op_valid_d;
    logic                  illegal_q, illegal_d;

    logic [CodeW-1:0] dec_code;
    logic             dec_multicycle;
    logic             dec_illegal;

    alu_op_decoder #(
        .ALUOP_WIDTH(ALUOP_WIDTH)
    ) u_decoder (
        .selector     ({ALUOp, ALUFunction}),
        .code         (dec_code),
        .is_multicycle(dec_multicycle),
        .illegal      (dec_illegal)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        op_valid_d = 1'b0;
        illegal_d  = 1'b0;
        ready_o    = 1'b0;
        hilo_write = 1'b0;

        case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                // flush_i is irrelevant here and must not block a transfer.
                if (valid_i) begin
                    op_d       = OPER_WIDTH'(dec_code);
                    op_valid_d = 1'b1;
                    illegal_d  = dec_illegal;
                    if (dec_multicycle) begin
                        state_d = StBusy;
                        cnt_d   = is_div_code(dec_code) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                    end
                end
            end
            StBusy: begin
                if (flush_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q <= CntW'(1)) begin
                    hilo_write = (cnt_q == CntW'(1));
                    state_d    = StIdle;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // A reset in the last busy cycle aborts the operation, so no HI/LO update.
        if (reset) begin
            hilo_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= OPER_WIDTH'(OpIllegal);
            op_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            illegal_q  <= illegal_d;
        end
    end

    assign stall        = ~ready_o;
    assign ALUOperation = op_q;
    assign op_valid     = op_valid_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_alu_seq_control.sv
// Self-checking bench for alu_seq_control: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_alu_seq_control;

    logic       clk;
    logic       reset;
    logic       valid_i;
    logic [2:0] alu_op;
    logic [5:0] alu_func;
    logic       flush_i;
    logic       ready_o;
    logic [4:0] alu_operation;
    logic       op_valid;
    logic       stall;
    logic       hilo_write;
    logic       illegal_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: remaining stall cycles, held code, one-cycle pulses.
    int m_left = 0;
    int m_op   = 9;
    bit m_ov   = 0;
    bit m_ill  = 0;

    alu_seq_control #(
        .ALUOP_WIDTH(3),
        .OPER_WIDTH (5),
        .MULT_CYCLES(4),
        .DIV_CYCLES (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (valid_i),
        .ALUOp       (alu_op),
        .ALUFunction (alu_func),
        .flush_i     (flush_i),
        .ready_o     (ready_o),
        .ALUOperation(alu_operation),
        .op_valid    (op_valid),
        .stall       (stall),
        .hilo_write  (hilo_write),
        .illegal_o   (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    function automatic int ref_code(logic [2:0] op, logic [5:0] f);
        case (op)
            3'b110: return 3;
            3'b101: return 1;
            3'b011: return 0;
            3'b001: return 2;
            3'b010: return 3;
            3'b100: return 3;
            3'b000: return 7;
            default: begin
                case (f)
                    6'b100100: return 0;
                    6'b100101: return 1;
                    6'b100111: return 5;
                    6'b100000: return 3;
                    6'b100001: return 3;
                    6'b100010: return 7;
                    6'b000000: return 4;
                    6'b000010: return 6;
                    6'b001000: return 8;
                    6'b101010: return 10;
                    6'b100110: return 11;
                    6'b011000: return 12;
                    6'b011001: return 13;
                    6'b011010: return 14;
                    6'b011011: return 15;
                    6'b010000: return 16;
                    6'b010010: return 17;
                    default:   return 9;
                endcase
            end
        endcase
    endfunction

    task automatic model_step();
        int  c;
        bit  xfer;
        if (reset) begin
            m_left = 0;
            m_op   = 9;
            m_ov   = 0;
            m_ill  = 0;
        end else begin
            xfer = valid_i && (m_left == 0);
            c    = ref_code(alu_op, alu_func);
            if (m_left > 0) m_left = flush_i ? 0 : m_left - 1;
            m_ov  = xfer;
            m_ill = xfer && (c == 9);
            if (xfer) begin
                m_op = c;
                if (c >= 12 && c <= 15) m_left = (c <= 13) ? 4 : 32;
            end
        end
    endtask

    // Advance one clock; inputs are stable since the previous posedge+1.
    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [2:0] op, input logic [5:0] f,
                          input bit fl, input bit rs);
        valid_i  = v;
        alu_op   = op;
        alu_func = f;
        flush_i  = fl;
        reset    = rs;
    endtask

    task automatic test_reset();
        set_in(1, 3'b111, 6'b100000, 0, 1);
        adv();
        adv();
        set_in(0, 3'b000, 6'b000000, 0, 0);
        @(negedge clk);
        n_checks += 6;
        if (alu_operation !== 5'd9) begin
            n_errors++; $display("FAIL reset_aluop: got %0d expected 9", alu_operation);
        end
        if (op_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_op_valid: got %b expected 0", op_valid);
        end
        if (hilo_write !== 1'b0) begin
            n_errors++; $display("FAIL reset_hilo: got %b expected 0", hilo_write);
        end
        if (illegal_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_illegal: got %b expected 0", illegal_o);
        end
        if (ready_o !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready: got %b expected 1", ready_o);
        end
        if (stall !== 1'b0) begin
            n_errors++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        adv();
    endtask

    task automatic test_add();
        set_in(1, 3'b111, 6'b100000, 0, 0);
        adv();
        set_in(0, 3'b000, 6'b000000, 0, 0);
        @(negedge clk);
        n_checks += 3;
        if (alu_operation !== 5'd3) begin
            n_errors++; $display("FAIL add_code: got %0d expected 3", alu_operation);
        end
        if (op_valid !== 1'b1) begin
            n_errors++; $display("FAIL add_op_valid: got %b expected 1", op_valid);
        end
        if (stall !== 1'b0) begin
            n_errors++; $display("FAIL add_stall: got %b expected 0", stall);
        end
        adv();
        @(negedge clk);
        n_checks += 2;
        if (op_valid !== 1'b0) begin
            n_errors++; $display("FAIL add_pulse_end: got %b expected 0", op_valid);
        end
        if (alu_operation !== 5'd3) begin
            n_errors++; $display("FAIL add_hold: got %0d expected 3", alu_operation);
        end
    endtask

    // MULT with ADD presented throughout BUSY; optionally flush in the last busy cycle.
    task automatic test_mult(input bit flush_last);
        set_in(1, 3'b111, 6'b011000, 0, 0);
        adv();
        for (int k = 1; k <= 4; k++) begin
            set_in(1, 3'b111, 6'b100000, flush_last && (k == 4), 0);
            @(negedge clk);
            n_checks += 3;
            if (stall !== 1'b1 || ready_o !== 1'b0) begin
                n_errors++;
                $display("FAIL mult_stall k=%0d: got stall=%b ready=%b expected 1/0",
                         k, stall, ready_o);
            end
            if (hilo_write !== (k == 4 && !flush_last)) begin
                n_errors++;
                $display("FAIL mult_hilo k=%0d: got %b expected %b",
                         k, hilo_write, (k == 4 && !flush_last));
            end
            if (alu_operation !== 5'd12 || op_valid !== (k == 1)) begin
                n_errors++;
                $display("FAIL mult_code k=%0d: got %0d/%b expected 12/%b",
                         k, alu_operation, op_valid, (k == 1));
            end
            adv();
        end
        set_in(0, 3'b000, 6'b000000, 0, 0);
        @(negedge clk);
        n_checks += 2;
        if (ready_o !== 1'b1 || hilo_write !== 1'b0) begin
            n_errors++;
            $display("FAIL mult_done: got ready=%b hilo=%b expected 1/0", ready_o, hilo_write);
        end
        if (alu_operation !== 5'd12 || op_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mult_ignore: got %0d/%b expected 12/0", alu_operation, op_valid);
        end
    endtask

    task automatic test_div_flush();
        int hilo_seen = 0;
        set_in(1, 3'b111, 6'b011010, 0, 0);
        adv();
        for (int k = 1; k <= 10; k++) begin
            set_in(0, 3'b000, 6'b000000, (k == 10), 0);
            @(negedge clk);
            if (hilo_write !== 1'b0) hilo_seen++;
            n_checks++;
            if (ready_o !== 1'b0) begin
                n_errors++; $display("FAIL div_busy k=%0d: got ready=%b expected 0", k, ready_o);
            end
            adv();
        end
        set_in(0, 3'b000, 6'b000000, 0, 0);
        @(negedge clk);
        if (hilo_write !== 1'b0) hilo_seen++;
        n_checks += 2;
        if (ready_o !== 1'b1) begin
            n_errors++; $display("FAIL div_flush_ready: got %b expected 1", ready_o);
        end
        if (hilo_seen != 0) begin
            n_errors++; $display("FAIL div_flush_hilo: got %0d strobes expected 0", hilo_seen);
        end
        adv();
    endtask

    task automatic test_illegal();
        set_in(1, 3'b111, 6'b111111, 0, 0);
        adv();
        set_in(1, 3'b111, 6'b101010, 0, 0);
        @(negedge clk);
        n_checks++;
        if (alu_operation !== 5'd9 || illegal_o !== 1'b1 || op_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_flag: got %0d/%b/%b expected 9/1/1",
                     alu_operation, illegal_o, op_valid);
        end
        adv();
        set_in(0, 3'b000, 6'b000000, 0, 0);
        @(negedge clk);
        n_checks++;
        if (alu_operation !== 5'd10 || illegal_o !== 1'b0 || op_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_then_slt: got %0d/%b/%b expected 10/0/1",
                     alu_operation, illegal_o, op_valid);
        end
        adv();
    endtask

    task automatic test_reset_busy();
        set_in(1, 3'b111, 6'b011000, 0, 0);
        adv();
        set_in(0, 3'b000, 6'b000000, 0, 0);
        adv();
        set_in(0, 3'b000, 6'b000000, 0, 1);
        adv();
        set_in(0, 3'b000, 6'b000000, 0, 0);
        @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b1 || alu_operation !== 5'd9 || hilo_write !== 1'b0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_busy: got ready=%b code=%0d hilo=%b stall=%b expected 1/9/0/0",
                     ready_o, alu_operation, hilo_write, stall);
        end
        adv();
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops[3];
        int         codes[3];
        ops[0] = 3'b010; ops[1] = 3'b000; ops[2] = 3'b101;
        codes[0] = 3; codes[1] = 7; codes[2] = 1;
        for (int i = 0; i < 3; i++) begin
            // flush_i in IDLE must not block the transfer.
            set_in(1, ops[i], 6'($urandom), (i == 1), 0);
            adv();
            set_in(0, 3'b000, 6'b000000, 0, 0);
            @(negedge clk);
            n_checks++;
            if (op_valid !== 1'b1 || alu_operation !== 5'(codes[i])) begin
                n_errors++;
                $display("FAIL b2b_%0d: got %0d/%b expected %0d/1",
                         i, alu_operation, op_valid, codes[i]);
            end
        end
        adv();
    endtask

    task automatic test_random();
        logic [5:0] functs[17];
        functs = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100001, 6'b100010,
                   6'b000000, 6'b000010, 6'b001000, 6'b101010, 6'b100110, 6'b011000,
                   6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010010};
        for (int n = 0; n < 1500; n++) begin
            valid_i  = ($urandom_range(0, 9) < 7);
            alu_op   = 3'($urandom);
            alu_func = ($urandom_range(0, 1) == 0) ? functs[$urandom_range(0, 16)]
                                                   : 6'($urandom);
            flush_i  = ($urandom_range(0, 9) == 0);
            reset    = ($urandom_range(0, 79) == 0);
            @(negedge clk);
            n_checks++;
            if (ready_o !== (m_left == 0) || stall !== (m_left != 0) ||
                hilo_write !== (m_left == 1 && !flush_i && !reset) ||
                alu_operation !== 5'(m_op) || op_valid !== m_ov || illegal_o !== m_ill) begin
                n_errors++;
                $display("FAIL random_%0d: got rdy=%b stl=%b hilo=%b op=%0d ov=%b ill=%b expected rdy=%b stl=%b hilo=%b op=%0d ov=%b ill=%b",
                         n, ready_o, stall, hilo_write, alu_operation, op_valid, illegal_o,
                         (m_left == 0), (m_left != 0), (m_left == 1 && !flush_i && !reset),
                         m_op, m_ov, m_ill);
            end
            adv();
        end
    endtask

    initial begin
        set_in(0, 3'b000, 6'b000000, 0, 1);
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_mult(1'b0);
        test_mult(1'b1);
        test_div_flush();
        test_illegal();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
